// File: rtl/video_mono_filter_if.sv
// Video bus between the pixel source, the colour-mode filter and the VGA DAC pins.
// The source side uses the master modport and the filter uses the slave modport.
interface video_mono_filter_if #(
  parameter int IN_W  = 6,
  parameter int OUT_W = 3
);
  logic [IN_W-1:0]  in_r;
  logic [IN_W-1:0]  in_g;
  logic [IN_W-1:0]  in_b;
  logic             in_hsync;
  logic             in_vsync;
  logic             in_blank;
  logic [1:0]       mode;
  logic             scan_en;
  logic [OUT_W-1:0] vga_r;
  logic [OUT_W-1:0] vga_g;
  logic [OUT_W-1:0] vga_b;
  logic             vga_hsync;
  logic             vga_vsync;
  logic [1:0]       mode_act;

  modport master (
    output in_r, in_g, in_b, in_hsync, in_vsync, in_blank, mode, scan_en,
    input  vga_r, vga_g, vga_b, vga_hsync, vga_vsync, mode_act
  );

  modport slave (
    input  in_r, in_g, in_b, in_hsync, in_vsync, in_blank, mode, scan_en,
    output vga_r, vga_g, vga_b, vga_hsync, vga_vsync, mode_act
  );
endinterface

// File: rtl/video_mono_filter.sv
// Three-stage colour-mode processor (colour/green/amber/grey) with frame-synchronous
// mode switching and optional odd-line dimming; data and syncs leave delay-matched.
module video_mono_filter #(
  parameter int IN_W   = 6,
  parameter int OUT_W  = 3,
  parameter int KR     = 54,
  parameter int KG     = 183,
  parameter int KB     = 19,
  parameter int HS_POL = 0,
  parameter int VS_POL = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  video_mono_filter_if.slave vid
);

  localparam int PW = IN_W + 8;
  localparam int SW = IN_W + 10;
  localparam logic [7:0] KR8 = 8'(KR);
  localparam logic [7:0] KG8 = 8'(KG);
  localparam logic [7:0] KB8 = 8'(KB);
  localparam logic HS_ACT = 1'(HS_POL);
  localparam logic VS_ACT = 1'(VS_POL);
  localparam logic [SW-1:0] Y_MAX = SW'((2 ** IN_W) - 1);

  typedef enum logic [1:0] {
    MODE_COLOUR = 2'b00,
    MODE_GREEN  = 2'b01,
    MODE_AMBER  = 2'b10,
    MODE_GREY   = 2'b11
  } mode_e;

  logic      hs_d;
  logic      vs_d;
  logic      line_par;
  logic      scan_act;
  mode_e     mode_act;
  logic      hs_lead;
  logic      vs_lead;

  logic [PW-1:0]   s1_pr, s1_pg, s1_pb;
  logic [IN_W-1:0] s1_r, s1_g, s1_b;
  logic            s1_blank, s1_hs, s1_vs, s1_par;

  logic [IN_W-1:0] s2_y, s2_r, s2_g, s2_b;
  logic            s2_blank, s2_hs, s2_vs, s2_par;

  logic [OUT_W-1:0] out_r, out_g, out_b;
  logic             out_hs, out_vs;

  logic [SW-1:0]   luma_sum;
  logic [SW-1:0]   luma_shr;
  logic [IN_W-1:0] y_next;
  logic [IN_W-1:0] sel_r, sel_g, sel_b;
  logic [IN_W-1:0] dim_r, dim_g, dim_b;
  logic            dim_on;

  assign hs_lead = (vid.in_hsync == HS_ACT) && (hs_d != HS_ACT);
  assign vs_lead = (vid.in_vsync == VS_ACT) && (vs_d != VS_ACT);

  // Mode and scanline enable only change on the VSYNC leading edge, which lies in blanking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_d     <= ~HS_ACT;
      vs_d     <= ~VS_ACT;
      mode_act <= MODE_COLOUR;
      scan_act <= 1'b0;
      line_par <= 1'b0;
    end else begin
      hs_d <= vid.in_hsync;
      vs_d <= vid.in_vsync;
      if (vs_lead) begin
        mode_act <= mode_e'(vid.mode);
        scan_act <= vid.scan_en;
        line_par <= 1'b0;
      end else if (hs_lead) begin
        line_par <= ~line_par;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_pr    <= '0;
      s1_pg    <= '0;
      s1_pb    <= '0;
      s1_r     <= '0;
      s1_g     <= '0;
      s1_b     <= '0;
      s1_blank <= 1'b1;
      s1_hs    <= ~HS_ACT;
      s1_vs    <= ~VS_ACT;
      s1_par   <= 1'b0;
    end else begin
      s1_pr    <= PW'(KR8) * PW'(vid.in_r);
      s1_pg    <= PW'(KG8) * PW'(vid.in_g);
      s1_pb    <= PW'(KB8) * PW'(vid.in_b);
      s1_r     <= vid.in_r;
      s1_g     <= vid.in_g;
      s1_b     <= vid.in_b;
      s1_blank <= vid.in_blank;
      s1_hs    <= vid.in_hsync;
      s1_vs    <= vid.in_vsync;
      s1_par   <= line_par;
    end
  end

  // Rounded luma; the clamp only matters when the weights sum above 256.
  always_comb begin
    luma_sum = SW'(s1_pr) + SW'(s1_pg) + SW'(s1_pb) + SW'(128);
    luma_shr = luma_sum >> 8;
    y_next   = '1;
    if (luma_shr <= Y_MAX) begin
      y_next = luma_shr[IN_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_y     <= '0;
      s2_r     <= '0;
      s2_g     <= '0;
      s2_b     <= '0;
      s2_blank <= 1'b1;
      s2_hs    <= ~HS_ACT;
      s2_vs    <= ~VS_ACT;
      s2_par   <= 1'b0;
    end else begin
      s2_y     <= y_next;
      s2_r     <= s1_r;
      s2_g     <= s1_g;
      s2_b     <= s1_b;
      s2_blank <= s1_blank;
      s2_hs    <= s1_hs;
      s2_vs    <= s1_vs;
      s2_par   <= s1_par;
    end
  end

  always_comb begin
    sel_r = s2_r;
    sel_g = s2_g;
    sel_b = s2_b;
    case (mode_act)
      MODE_GREEN: begin
        sel_r = '0;
        sel_g = s2_y;
        sel_b = '0;
      end
      MODE_AMBER: begin
        sel_r = s2_y;
        sel_g = s2_y >> 1;
        sel_b = '0;
      end
      MODE_GREY: begin
        sel_r = s2_y;
        sel_g = s2_y;
        sel_b = s2_y;
      end
      default: begin
        sel_r = s2_r;
        sel_g = s2_g;
        sel_b = s2_b;
      end
    endcase
    dim_on = scan_act && s2_par;
    dim_r  = sel_r;
    dim_g  = sel_g;
    dim_b  = sel_b;
    if (dim_on) begin
      dim_r = sel_r - (sel_r >> 2);
      dim_g = sel_g - (sel_g >> 2);
      dim_b = sel_b - (sel_b >> 2);
    end
  end

  // Output keeps the top OUT_W bits of each component with no rounding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r  <= '0;
      out_g  <= '0;
      out_b  <= '0;
      out_hs <= ~HS_ACT;
      out_vs <= ~VS_ACT;
    end else begin
      out_hs <= s2_hs;
      out_vs <= s2_vs;
      if (s2_blank) begin
        out_r <= '0;
        out_g <= '0;
        out_b <= '0;
      end else begin
        out_r <= OUT_W'(dim_r >> (IN_W - OUT_W));
        out_g <= OUT_W'(dim_g >> (IN_W - OUT_W));
        out_b <= OUT_W'(dim_b >> (IN_W - OUT_W));
      end
    end
  end

  assign vid.vga_r     = out_r;
  assign vid.vga_g     = out_g;
  assign vid.vga_b     = out_b;
  assign vid.vga_hsync = out_hs;
  assign vid.vga_vsync = out_vs;
  assign vid.mode_act  = mode_act;

endmodule
